y_multicycle_ctrl: RTL and testbench

Y_MULTICYCLE_CTRL -- requirements
Module: y_multicycle_ctrl

---
 rtl/y_multicycle_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_y_multicycle_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/y_multicycle_ctrl.sv
// Multicycle RV32I-subset control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with memory wait timeout.
// Optional performance counters are enabled by defining Y_MULTICYCLE_CTRL_PERF_EN.
module y_multicycle_ctrl #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] ins,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        ir_we,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [2:0]  op,
  output logic [1:0]  wb_sel,
  output logic        busy,
  output logic        halted,
  output logic        fault,
  output logic [31:0] cyc_cnt,
  output logic [31:0] ret_cnt
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT
  } state_e;

  typedef enum logic [2:0] {
    C_R, C_I, C_LW, C_SW, C_BEQ, C_JAL, C_BAD
  } cls_e;

  localparam logic [6:0]  OPC_R    = 7'b0110011;
  localparam logic [6:0]  OPC_I    = 7'b0010011;
  localparam logic [6:0]  OPC_LW   = 7'b0000011;
  localparam logic [6:0]  OPC_SW   = 7'b0100011;
  localparam logic [6:0]  OPC_BEQ  = 7'b1100011;
  localparam logic [6:0]  OPC_JAL  = 7'b1101111;
  localparam logic [31:0] INS_HALT = 32'h0000_0073;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] WB_ALU    = 2'b00;
  localparam logic [1:0] WB_MEM    = 2'b01;
  localparam logic [1:0] WB_PC4    = 2'b10;

  // Wait counter value on the last permitted cycle of a FETCH/MEM access.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  state_e     state_q, state_d;
  cls_e       cls_q, cls_d, dec_cls;
  logic [2:0] op_q, op_d, dec_op;
  logic [7:0] wait_q, wait_d;
  logic       wait_last;
  logic       src_imm;

  // Instruction classifier; only consumed while in DECODE.
  always_comb begin
    dec_cls = C_BAD;
    dec_op  = OP_ADD;
    case (ins[6:0])
      OPC_R: begin
        if (ins[31:25] == 7'b0000000) begin
          dec_cls = C_R;
          case (ins[14:12])
            3'b000:  dec_op = OP_ADD;
            3'b111:  dec_op = OP_AND;
            3'b110:  dec_op = OP_OR;
            3'b010:  dec_op = OP_SLT;
            default: dec_cls = C_BAD;
          endcase
        end else if (ins[31:25] == 7'b0100000 && ins[14:12] == 3'b000) begin
          dec_cls = C_R;
          dec_op  = OP_SUB;
        end
      end
      OPC_I: begin
        dec_cls = C_I;
        case (ins[14:12])
          3'b000:  dec_op = OP_ADD;
          3'b111:  dec_op = OP_AND;
          3'b110:  dec_op = OP_OR;
          3'b010:  dec_op = OP_SLT;
          default: dec_cls = C_BAD;
        endcase
      end
      OPC_LW:  if (ins[14:12] == 3'b010) dec_cls = C_LW;
      OPC_SW:  if (ins[14:12] == 3'b010) dec_cls = C_SW;
      OPC_BEQ: begin
        if (ins[14:12] == 3'b000) begin
          dec_cls = C_BEQ;
          dec_op  = OP_SUB;
        end
      end
      OPC_JAL: dec_cls = C_JAL;
      default: dec_cls = C_BAD;
    endcase
  end

  assign src_imm   = (cls_q == C_I) || (cls_q == C_LW) || (cls_q == C_SW);
  assign wait_last = (wait_q == WAIT_LAST);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cls_d    = cls_q;
    op_d     = op_q;
    pc_we    = 1'b0;
    pc_sel   = PC_PLUS4;
    ir_we    = 1'b0;
    RegWrite = 1'b0;
    ALUSrc   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    op       = OP_AND;
    wb_sel   = WB_ALU;
    busy     = 1'b0;
    halted   = 1'b0;
    fault    = 1'b0;

    case (state_q)
      IDLE: if (start) state_d = FETCH;
      FETCH: begin
        busy    = 1'b1;
        MemRead = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = DECODE;
        end else if (wait_last) begin
          state_d = FAULT;
        end
      end
      DECODE: begin
        busy  = 1'b1;
        cls_d = dec_cls;
        op_d  = dec_op;
        if (ins == INS_HALT)     state_d = HALT;
        else if (dec_cls == C_BAD) state_d = FAULT;
        else                     state_d = EXEC;
      end
      EXEC: begin
        busy   = 1'b1;
        ALUSrc = src_imm;
        op     = op_q;
        case (cls_q)
          C_R, C_I:   state_d = WB;
          C_LW, C_SW: state_d = MEM;
          C_BEQ: begin
            pc_we   = 1'b1;
            pc_sel  = zero ? PC_BRANCH : PC_PLUS4;
            state_d = FETCH;
          end
          C_JAL: begin
            RegWrite = 1'b1;
            wb_sel   = WB_PC4;
            pc_we    = 1'b1;
            pc_sel   = PC_JUMP;
            state_d  = FETCH;
          end
          default: state_d = FAULT;
        endcase
      end
      MEM: begin
        busy     = 1'b1;
        ALUSrc   = src_imm;
        op       = op_q;
        MemRead  = (cls_q == C_LW);
        MemWrite = (cls_q != C_LW);
        if (mem_ready) begin
          if (cls_q == C_LW) begin
            state_d = WB;
          end else begin
            pc_we   = 1'b1;
            state_d = FETCH;
          end
        end else if (wait_last) begin
          state_d = FAULT;
        end
      end
      WB: begin
        busy     = 1'b1;
        ALUSrc   = src_imm;
        op       = op_q;
        RegWrite = 1'b1;
        wb_sel   = (cls_q == C_LW) ? WB_MEM : WB_ALU;
        pc_we    = 1'b1;
        state_d  = FETCH;
      end
      HALT:    halted = 1'b1;
      FAULT:   fault  = 1'b1;
      default: state_d = FAULT;
    endcase

    // Counter restarts whenever a FETCH or MEM access begins.
    if (state_d == state_q && (state_q == FETCH || state_q == MEM)) wait_d = wait_q + 8'd1;
    else                                                            wait_d = 8'd0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the latched decode is reset too, keeping outputs X-free straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cls_q   <= C_BAD;
      op_q    <= OP_AND;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
    end
  end

`ifdef Y_MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cyc_q, ret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= 32'd0;
      ret_q <= 32'd0;
    end else begin
      if (busy)  cyc_q <= cyc_q + 32'd1;
      if (pc_we) ret_q <= ret_q + 32'd1;
    end
  end

  assign cyc_cnt = cyc_q;
  assign ret_cnt = ret_q;
`else
  assign cyc_cnt = 32'd0;
  assign ret_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_y_multicycle_ctrl.sv
// Self-checking bench for y_multicycle_ctrl: per-instruction vector table scored at retirement,
// plus hand-written sequences for halt/fault absorption, async reset and counters.
module tb_y_multicycle_ctrl;

  localparam int K_RET   = 0;
  localparam int K_HALT  = 1;
  localparam int K_FAULT = 2;
  localparam int NEVER   = 255;

  typedef struct {
    logic [31:0] ins;
    logic        zero;
    int          fdly;
    int          mdly;
    int          kind;
    int          cycles;
    logic [1:0]  pc_sel;
    logic        regw;
    logic [1:0]  wb_sel;
    logic        chk_op;
    logic [2:0]  op;
    logic        alusrc;
    int          irw;
    int          mrd;
    int          mwr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] ins = 32'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_we, ir_we, RegWrite, ALUSrc, MemRead, MemWrite;
  logic        busy, halted, fault;
  logic [1:0]  pc_sel, wb_sel;
  logic [2:0]  op;
  logic [31:0] cyc_cnt, ret_cnt;

  int n_pass = 0;
  int n_checks = 0;

  vec_t sb[$];
  vec_t tbl[$];
  int   cur_idx = 0;

  int   fetch_dly = 0;
  int   mem_dly = 0;
  int   acc = 0;

  int         m_cyc, m_since, m_irw, m_mrd, m_mwr;
  logic [2:0] m_op;
  logic       m_src;
  bit         m_done;
  bit         both_seen = 1'b0;

  y_multicycle_ctrl #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ins(ins), .zero(zero),
    .mem_ready(mem_ready), .pc_we(pc_we), .pc_sel(pc_sel), .ir_we(ir_we),
    .RegWrite(RegWrite), .ALUSrc(ALUSrc), .MemRead(MemRead), .MemWrite(MemWrite),
    .op(op), .wb_sel(wb_sel), .busy(busy), .halted(halted), .fault(fault),
    .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: event not expected or never arrived", name);
  endtask

  task automatic mon_clear();
    m_cyc = 0; m_since = -1; m_irw = 0; m_mrd = 0; m_mwr = 0;
    m_op = 3'd0; m_src = 1'b0; m_done = 1'b0;
  endtask

  // Memory model: answers mem_ready after a per-access latency (ALUSrc separates MEM from FETCH).
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!rst_n || !(MemRead || MemWrite)) begin
        acc = 0;
        mem_ready = 1'b0;
      end else begin
        mem_ready = (acc >= (ALUSrc ? mem_dly : fetch_dly));
        acc = mem_ready ? 0 : acc + 1;
      end
    end
  end

  // Monitor: gathers per-instruction observations, scores them against the queue at the end event.
  initial begin
    vec_t e;
    int   kind;
    mon_clear();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_clear();
      end else begin
        if (MemRead && MemWrite) both_seen = 1'b1;
        if (busy) m_cyc++;
        if (m_since >= 0) m_since++;
        if (ir_we) begin m_irw++; m_since = 0; end
        if (m_since == 2) begin m_op = op; m_src = ALUSrc; end
        if (m_since >= 1) begin
          if (MemRead)  m_mrd++;
          if (MemWrite) m_mwr++;
        end
        if (!m_done && (pc_we || halted || fault)) begin
          m_done = 1'b1;
          if (sb.size() == 0) begin
            fail_now($sformatf("v%0d unexpected_end", cur_idx));
          end else begin
            e = sb.pop_front();
            kind = pc_we ? K_RET : (halted ? K_HALT : K_FAULT);
            check($sformatf("v%0d kind", cur_idx), 32'(kind), 32'(e.kind));
            check($sformatf("v%0d cycles", cur_idx), 32'(m_cyc), 32'(e.cycles));
            check($sformatf("v%0d pc_sel", cur_idx), 32'(pc_sel), 32'(e.pc_sel));
            check($sformatf("v%0d RegWrite", cur_idx), 32'(RegWrite), 32'(e.regw));
            check($sformatf("v%0d wb_sel", cur_idx), 32'(wb_sel), 32'(e.wb_sel));
            check($sformatf("v%0d ir_we_pulses", cur_idx), 32'(m_irw), 32'(e.irw));
            check($sformatf("v%0d memread_cycles", cur_idx), 32'(m_mrd), 32'(e.mrd));
            check($sformatf("v%0d memwrite_cycles", cur_idx), 32'(m_mwr), 32'(e.mwr));
            if (e.chk_op) begin
              check($sformatf("v%0d exec_op", cur_idx), 32'(m_op), 32'(e.op));
              check($sformatf("v%0d exec_alusrc", cur_idx), 32'(m_src), 32'(e.alusrc));
            end
          end
        end
      end
    end
  end

  task automatic issue(input vec_t v, input bit push);
    @(negedge clk); #1;
    rst_n = 1'b0;
    start = 1'b0;
    ins = v.ins; zero = v.zero;
    fetch_dly = v.fdly; mem_dly = v.mdly;
    acc = 0; mem_ready = 1'b0;
    mon_clear();
    #2 rst_n = 1'b1;
    if (push) sb.push_back(v);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      if (sb.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      fail_now($sformatf("v%0d timeout", cur_idx));
      sb.delete();
    end
  endtask

  initial begin
    //                ins           z     fd     md     kind     cyc  pcs    rw    wb     chk   op      src   irw mrd mwr
    tbl.push_back(vec_t'{32'h002081B3, 1'b0, 0,     0,     K_RET,   4,  2'b00, 1'b1, 2'b00, 1'b1, 3'b010, 1'b0, 1,  0,  0});  // add
    tbl.push_back(vec_t'{32'h402081B3, 1'b0, 0,     0,     K_RET,   4,  2'b00, 1'b1, 2'b00, 1'b1, 3'b110, 1'b0, 1,  0,  0});  // sub
    tbl.push_back(vec_t'{32'h0020F1B3, 1'b0, 0,     0,     K_RET,   4,  2'b00, 1'b1, 2'b00, 1'b1, 3'b000, 1'b0, 1,  0,  0});  // and
    tbl.push_back(vec_t'{32'h0020E1B3, 1'b0, 0,     0,     K_RET,   4,  2'b00, 1'b1, 2'b00, 1'b1, 3'b001, 1'b0, 1,  0,  0});  // or
    tbl.push_back(vec_t'{32'h0020A1B3, 1'b0, 0,     0,     K_RET,   4,  2'b00, 1'b1, 2'b00, 1'b1, 3'b111, 1'b0, 1,  0,  0});  // slt
    tbl.push_back(vec_t'{32'h00500093, 1'b0, 0,     0,     K_RET,   4,  2'b00, 1'b1, 2'b00, 1'b1, 3'b010, 1'b1, 1,  0,  0});  // addi
    tbl.push_back(vec_t'{32'h00507093, 1'b0, 0,     0,     K_RET,   4,  2'b00, 1'b1, 2'b00, 1'b1, 3'b000, 1'b1, 1,  0,  0});  // andi
    tbl.push_back(vec_t'{32'h00506093, 1'b0, 0,     0,     K_RET,   4,  2'b00, 1'b1, 2'b00, 1'b1, 3'b001, 1'b1, 1,  0,  0});  // ori
    tbl.push_back(vec_t'{32'h00502093, 1'b0, 0,     0,     K_RET,   4,  2'b00, 1'b1, 2'b00, 1'b1, 3'b111, 1'b1, 1,  0,  0});  // slti
    tbl.push_back(vec_t'{32'h00012083, 1'b0, 0,     3,     K_RET,   8,  2'b00, 1'b1, 2'b01, 1'b1, 3'b010, 1'b1, 1,  4,  0});  // lw, ready after 3
    tbl.push_back(vec_t'{32'h00012083, 1'b0, 0,     14,    K_RET,   19, 2'b00, 1'b1, 2'b01, 1'b1, 3'b010, 1'b1, 1,  15, 0});  // lw, ready on last allowed cycle
    tbl.push_back(vec_t'{32'h00012083, 1'b0, 0,     15,    K_FAULT, 18, 2'b00, 1'b0, 2'b00, 1'b1, 3'b010, 1'b1, 1,  15, 0});  // lw, one cycle too late
    tbl.push_back(vec_t'{32'h00112023, 1'b0, 0,     0,     K_RET,   4,  2'b00, 1'b0, 2'b00, 1'b1, 3'b010, 1'b1, 1,  0,  1});  // sw
    tbl.push_back(vec_t'{32'h00112023, 1'b0, 0,     NEVER, K_FAULT, 18, 2'b00, 1'b0, 2'b00, 1'b1, 3'b010, 1'b1, 1,  0,  15}); // sw, never ready
    tbl.push_back(vec_t'{32'h00208063, 1'b1, 0,     0,     K_RET,   3,  2'b01, 1'b0, 2'b00, 1'b1, 3'b110, 1'b0, 1,  0,  0});  // beq taken
    tbl.push_back(vec_t'{32'h00208063, 1'b0, 0,     0,     K_RET,   3,  2'b00, 1'b0, 2'b00, 1'b1, 3'b110, 1'b0, 1,  0,  0});  // beq not taken
    tbl.push_back(vec_t'{32'h000000EF, 1'b0, 0,     0,     K_RET,   3,  2'b10, 1'b1, 2'b10, 1'b0, 3'b000, 1'b0, 1,  0,  0});  // jal
    tbl.push_back(vec_t'{32'h00000073, 1'b0, 0,     0,     K_HALT,  2,  2'b00, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1,  0,  0});  // ecall -> halt
    tbl.push_back(vec_t'{32'h0000007F, 1'b0, 0,     0,     K_FAULT, 2,  2'b00, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1,  0,  0});  // bad opcode
    tbl.push_back(vec_t'{32'h00101093, 1'b0, 0,     0,     K_FAULT, 2,  2'b00, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1,  0,  0});  // slli unsupported
    tbl.push_back(vec_t'{32'h4020A1B3, 1'b0, 0,     0,     K_FAULT, 2,  2'b00, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1,  0,  0});  // slt with bad funct7
    tbl.push_back(vec_t'{32'h00209063, 1'b0, 0,     0,     K_FAULT, 2,  2'b00, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1,  0,  0});  // bne unsupported
    tbl.push_back(vec_t'{32'h002081B3, 1'b0, 2,     0,     K_RET,   6,  2'b00, 1'b1, 2'b00, 1'b1, 3'b010, 1'b0, 1,  0,  0});  // add, slow fetch
    tbl.push_back(vec_t'{32'h002081B3, 1'b0, NEVER, 0,     K_FAULT, 15, 2'b00, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 0,  0,  0});  // fetch timeout

    // Reset state
    #3;
    check("reset_strobes",
          32'({pc_we, pc_sel, ir_we, RegWrite, ALUSrc, MemRead, MemWrite, op, wb_sel, busy, halted, fault}),
          32'd0);
    check("reset_cyc_cnt", cyc_cnt, 32'd0);
    check("reset_ret_cnt", ret_cnt, 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      cur_idx = i;
      issue(tbl[i], 1'b1);
      wait_done(60);
    end

    // Halt is absorbing: start is ignored
    cur_idx = 100;
    issue(tbl[17], 1'b1);
    wait_done(20);
    start = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("halt_sticky_halted", 32'(halted), 32'd1);
    check("halt_sticky_busy", 32'(busy), 32'd0);
    start = 1'b0;

    // Fault is absorbing: no further write strobe after a SW timeout
    cur_idx = 101;
    issue(tbl[13], 1'b1);
    wait_done(60);
    repeat (3) @(negedge clk);
    check("fault_sticky_fault", 32'(fault), 32'd1);
    check("fault_memwrite_low", 32'(MemWrite), 32'd0);

    // Asynchronous reset in the middle of a SW access
    cur_idx = 102;
    issue(tbl[13], 1'b0);
    for (int k = 0; k < 20 && !MemWrite; k++) @(negedge clk);
    check("sw_mem_reached", 32'(MemWrite), 32'd1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_memwrite", 32'(MemWrite), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_cyc_cnt", cyc_cnt, 32'd0);
    check("async_rst_ret_cnt", ret_cnt, 32'd0);

    // Reset release waits for the next clock edge before leaving IDLE
    start = 1'b1;
    @(negedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("release_no_early_move", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("release_first_edge", 32'(busy), 32'd1);
    start = 1'b0;

    // Performance counters after one ADD retires
    cur_idx = 103;
    issue(tbl[0], 1'b1);
    wait_done(20);
    @(negedge clk);
`ifdef Y_MULTICYCLE_CTRL_PERF_EN
    check("perf_cyc_cnt", cyc_cnt, 32'd4);
    check("perf_ret_cnt", ret_cnt, 32'd1);
`else
    check("perf_cyc_cnt", cyc_cnt, 32'd0);
    check("perf_ret_cnt", ret_cnt, 32'd0);
`endif

    check("memread_memwrite_exclusive", 32'(both_seen), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
